// File: rtl/pat_search_pkg.sv
// rtl/pat_search_pkg.sv - shared types, widths and default addresses for the pattern search engine
package pat_search_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] DEF_PAT_ADDR  = 8'd6;
  localparam logic [ADDR_W-1:0] DEF_CNT_ADDR  = 8'd7;
  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 8'd32;
  localparam int                DEF_LEN       = 64;

  typedef enum logic [2:0] {
    RD_PAT = 3'd0,
    SCAN   = 3'd1,
    DRAIN  = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/pat_search_engine_if.sv
// rtl/pat_search_engine_if.sv - single-port data memory bus between engine (master) and memory (slave)
interface pat_search_engine_if;
  import pat_search_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wr_data;

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data,
    output mem_rd_data
  );

endinterface

// File: rtl/pat_search_engine_nibble_match.sv
// rtl/pat_search_engine_nibble_match.sv - hit when pattern equals any of the five 4-bit windows of a byte
module nibble_match (
  input  logic [7:0] data_byte,
  input  logic [3:0] pattern,
  output logic       hit
);

  always_comb begin
    hit = 1'b0;
    for (int o = 0; o <= 4; o++) begin
      if (data_byte[o +: 4] == pattern) hit = 1'b1;
    end
  end

endmodule

// File: rtl/pat_search_engine.sv
// rtl/pat_search_engine.sv - counts bytes in a memory window containing a 4-bit pattern; optional PAT_SEARCH_CYCLE_CT_EN cycle counter
module pat_search_engine
  import pat_search_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PAT_ADDR  = DEF_PAT_ADDR,
  parameter logic [ADDR_W-1:0] CNT_ADDR  = DEF_CNT_ADDR,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int                LEN       = DEF_LEN
) (
  input  logic                clk,
  input  logic                reset,
  pat_search_engine_if.master mem,
  output logic                done
`ifdef PAT_SEARCH_CYCLE_CT_EN
  ,
  output logic [15:0]         cycle_ct
`endif
);

  localparam logic [2:0] S_RD_PAT = RD_PAT;
  localparam logic [2:0] S_SCAN   = SCAN;
  localparam logic [2:0] S_DRAIN  = DRAIN;
  localparam logic [2:0] S_WRITE  = WRITE;
  localparam logic [2:0] S_DONE   = DONE;

  localparam logic [7:0] LEN_B = LEN[7:0];

  logic [2:0] state;
  logic [3:0] pattern;
  logic [7:0] count;
  logic [7:0] count_next;
  logic [7:0] idx;
  logic       hit;
  logic       eval;

  nibble_match u_match (
    .data_byte (mem.mem_rd_data),
    .pattern   (pattern),
    .hit       (hit)
  );

  // idx==1 is the cycle where read data is still the pattern byte
  assign eval = ((state == S_SCAN) && (idx != 8'd1)) || (state == S_DRAIN);

  always_comb begin
    count_next = count;
    if (eval && hit && (count != 8'hFF)) count_next = count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_RD_PAT;
      mem.mem_addr    <= PAT_ADDR;
      mem.mem_wr_en   <= 1'b0;
      mem.mem_wr_data <= '0;
      done            <= 1'b0;
      count           <= '0;
      pattern         <= '0;
      idx             <= '0;
    end else begin
      case (state)
        S_RD_PAT: begin
          state        <= S_SCAN;
          mem.mem_addr <= BASE_ADDR;
          idx          <= 8'd1;
        end
        S_SCAN: begin
          if (idx == 8'd1) pattern <= mem.mem_rd_data[3:0];
          count <= count_next;
          // idx counts addresses already issued, so the scan never wraps the address
          if (idx == LEN_B) begin
            state        <= S_DRAIN;
            mem.mem_addr <= CNT_ADDR;
          end else begin
            mem.mem_addr <= mem.mem_addr + 8'd1;
            idx          <= idx + 8'd1;
          end
        end
        S_DRAIN: begin
          count           <= count_next;
          mem.mem_wr_en   <= 1'b1;
          mem.mem_wr_data <= count_next;
          mem.mem_addr    <= CNT_ADDR;
          state           <= S_WRITE;
        end
        S_WRITE: begin
          mem.mem_wr_en <= 1'b0;
          done          <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: begin
          mem.mem_wr_en <= 1'b0;
          mem.mem_addr  <= CNT_ADDR;
        end
        default: state <= S_RD_PAT;
      endcase
    end
  end

`ifdef PAT_SEARCH_CYCLE_CT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_ct <= '0;
    end else if (!done && (cycle_ct != 16'hFFFF)) begin
      cycle_ct <= cycle_ct + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pat_search_engine.sv
// tb/tb_pat_search_engine.sv - directed bench for pat_search_engine, default and wide-window instances
module tb_pat_search_engine;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  logic done_a, done_b;
`ifdef PAT_SEARCH_CYCLE_CT_EN
  logic [15:0] cyc_ct_a, cyc_ct_b;
`endif

  always #5 clk = ~clk;

  pat_search_engine_if ifa ();
  pat_search_engine_if ifb ();

  pat_search_engine u_dut_a (
    .clk      (clk),
    .reset    (reset_a),
    .mem      (ifa.master),
    .done     (done_a)
`ifdef PAT_SEARCH_CYCLE_CT_EN
    ,
    .cycle_ct (cyc_ct_a)
`endif
  );

  pat_search_engine #(
    .BASE_ADDR (8'd1),
    .LEN       (255)
  ) u_dut_b (
    .clk      (clk),
    .reset    (reset_b),
    .mem      (ifb.master),
    .done     (done_b)
`ifdef PAT_SEARCH_CYCLE_CT_EN
    ,
    .cycle_ct (cyc_ct_b)
`endif
  );

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  int         wr_a = 0, bad_wr_a = 0, wr_b = 0;
  logic [7:0] last_wr_a = 8'h00, last_wr_b = 8'h00;

  // memory contents are owned by the stimulus; DUT writes are recorded here
  always @(posedge clk) begin
    ifa.mem_rd_data <= mem_a[ifa.mem_addr];
    ifb.mem_rd_data <= mem_b[ifb.mem_addr];
    if (ifa.mem_wr_en) begin
      wr_a      <= wr_a + 1;
      last_wr_a <= ifa.mem_wr_data;
      if (ifa.mem_addr != 8'd7) bad_wr_a <= bad_wr_a + 1;
    end
    if (ifb.mem_wr_en) begin
      wr_b      <= wr_b + 1;
      last_wr_b <= ifb.mem_wr_data;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_hit(input logic [7:0] b, input logic [3:0] p);
    logic [7:0] s;
    for (int o = 0; o < 5; o++) begin
      s = b >> o;
      if (s[3:0] == p) return 1;
    end
    return 0;
  endfunction

  task automatic pulse_reset_a();
    @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  // called right after a negedge; returns first cycle at which done is high (0 on timeout)
  task automatic release_wait_a(output int cyc);
    reset_a = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (done_a) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int w0;
    int exp_cnt;
    int seed;

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[6] = 8'h0D;

    repeat (3) @(negedge clk);
    check("rst_addr", int'(ifa.mem_addr), 6);
    check("rst_wr_en", int'(ifa.mem_wr_en), 0);
    check("rst_wr_data", int'(ifa.mem_wr_data), 0);
    check("rst_done", int'(done_a), 0);
`ifdef PAT_SEARCH_CYCLE_CT_EN
    check("rst_cycle_ct", int'(cyc_ct_a), 0);
`endif

    // all-zero window, pattern 1101
    w0 = wr_a;
    release_wait_a(cyc);
    check("zero_done_cycle", cyc, 67);
    check("zero_count", int'(last_wr_a), 0);
    check("zero_writes", wr_a - w0, 1);
`ifdef PAT_SEARCH_CYCLE_CT_EN
    check("cycle_ct_at_done", int'(cyc_ct_a), 67);
    repeat (10) @(negedge clk);
    check("cycle_ct_frozen", int'(cyc_ct_a), 67);
`endif
    repeat (5) @(negedge clk);
    check("zero_done_held", int'(done_a), 1);
    check("zero_no_extra_wr", wr_a - w0, 1);
    check("zero_idle_addr", int'(ifa.mem_addr), 7);

    // upper pattern bits ignored, byte counted once
    mem_a[6]  = 8'hFD;
    mem_a[32] = 8'h1A;
    mem_a[33] = 8'hDD;
    pulse_reset_a();
    w0 = wr_a;
    release_wait_a(cyc);
    check("once_done_cycle", cyc, 67);
    check("once_count", int'(last_wr_a), 2);
    check("once_writes", wr_a - w0, 1);

    // pattern 0000 over an all-zero window
    mem_a[6]  = 8'h00;
    mem_a[32] = 8'h00;
    mem_a[33] = 8'h00;
    pulse_reset_a();
    release_wait_a(cyc);
    check("pat0_count", int'(last_wr_a), 64);

    // saturating count on the 255-byte window instance
    @(negedge clk);
    reset_b = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (done_b) begin
        cyc = i;
        break;
      end
    end
    check("sat_done_cycle", cyc, 258);
    check("sat_count", int'(last_wr_b), 255);
    check("sat_writes", wr_b, 1);

    // seeded random window against the reference rule
    seed = 32'h5eed;
    for (int i = 0; i < 256; i++) mem_a[i] = 8'($random(seed));
    mem_a[6] = 8'h0D;
    exp_cnt = 0;
    for (int i = 32; i < 96; i++) exp_cnt += model_hit(mem_a[i], 4'hD);
    pulse_reset_a();
    w0 = wr_a;
    release_wait_a(cyc);
    check("rand_done_cycle", cyc, 67);
    check("rand_count", int'(last_wr_a), exp_cnt);
    check("rand_writes", wr_a - w0, 1);
    check("rand_stray_writes", bad_wr_a, 0);

    // reset reasserted at cycle 20 for two cycles
    pulse_reset_a();
    w0 = wr_a;
    reset_a = 1'b0;
    repeat (20) @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    check("midrst_addr", int'(ifa.mem_addr), 6);
    check("midrst_wr_en", int'(ifa.mem_wr_en), 0);
    @(negedge clk);
    check("midrst_no_write", wr_a - w0, 0);
    release_wait_a(cyc);
    check("midrst_done_cycle", cyc, 67);
    check("midrst_count", int'(last_wr_a), exp_cnt);
    check("midrst_writes", wr_a - w0, 1);
    check("midrst_stray_writes", bad_wr_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
